// File: rtl/spi_cmd_sequencer.sv
// Instruction queue and issue sequencer that feeds packed SPI instructions to the master.
// Supports one-shot draining of the queue and a replay mode that loops the stored program until abort.
module spi_cmd_sequencer #(
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 8,
  parameter int NSLV   = 4,
  parameter int DEPTH  = 8,
  localparam int SSW   = (NSLV > 1) ? $clog2(NSLV) : 1,
  localparam int CW    = SSW + DWIDTH + AWIDTH + 3,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [CW-1:0] cmd_data_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          repeat_en_i,
  input  logic [1:0]    cfg_in_i,
  input  logic          driver_read_i,
  output logic          master_en_o,
  output logic [CW-1:0] driver_data_o,
  output logic [1:0]    driver_cfg_o,
  output logic [LW-1:0] level_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rep_ptr_q, rep_ptr_d;
  logic [PW-1:0] rep_next;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] data_q, data_d;
  logic [1:0]    cfg_q, cfg_d;
  logic          repeat_q, repeat_d;
  logic          push, pop;
  logic [CW-1:0] mem_q [DEPTH];

  assign busy_o        = (state_q != IDLE);
  assign master_en_o   = (state_q == RUN);
  assign done_o        = (state_q == DONE);
  assign level_o       = level_q;
  assign driver_data_o = data_q;
  assign driver_cfg_o  = cfg_q;
  // A replaying program is frozen, so the host may not append to it.
  assign cmd_ready_o   = (level_q < LW'(DEPTH)) && !(busy_o && repeat_q);
  assign rep_next      = rep_ptr_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rep_ptr_d = rep_ptr_q;
    level_d   = level_q;
    data_d    = data_q;
    cfg_d     = cfg_q;
    repeat_d  = repeat_q;
    push      = cmd_valid_i && cmd_ready_o && !abort_i;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && (level_q != '0)) begin
          state_d   = RUN;
          repeat_d  = repeat_en_i;
          cfg_d     = cfg_in_i;
          rep_ptr_d = rd_ptr_q;
        end
      end
      RUN: begin
        if (driver_read_i) begin
          if (level_q == '0) begin
            state_d = LAST;
          end else if (repeat_q) begin
            // Walk the stored entries and wrap from the newest back to the oldest.
            data_d    = mem_q[rep_ptr_q];
            rep_ptr_d = (rep_next == wr_ptr_q) ? rd_ptr_q : rep_next;
          end else begin
            data_d = mem_q[rd_ptr_q];
            pop    = 1'b1;
          end
        end
      end
      LAST: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (abort_i) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rep_ptr_d = '0;
      level_d   = '0;
      repeat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rep_ptr_q <= '0;
      level_q   <= '0;
      data_q    <= '0;
      cfg_q     <= '0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rep_ptr_q <= rep_ptr_d;
      level_q   <= level_d;
      data_q    <= data_d;
      cfg_q     <= cfg_d;
      repeat_q  <= repeat_d;
    end
  end

  // Storage needs no reset; the pointers and level define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_data_i;
    end
  end

endmodule
